// File: rtl/adc_dma_pkg.sv
// Shared types and constants for the ADC DMA write master.
package adc_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAPT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int HALF_W = 16;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] ADDR_STEP = 32'd4;

endpackage

// File: rtl/adc_dma_wr_fifo.sv
// Synchronous FIFO for packed words; also exposes the entry behind the head
// so a registered consumer can advance without a bubble.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic         two_plus,
    output logic [W-1:0] head,
    output logic [W-1:0] head_next
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_en;
    logic          rd_en;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign wr_en     = push && (!full || pop);
    assign rd_en     = pop && !empty;
    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign two_plus  = (count >= (AW+1)'(2));
    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + AW'(1)];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_dma_wr.sv
// DMA write master: packs pairs of ADC samples into 32-bit words, buffers them
// and writes them to consecutive SDRAM word addresses over the fabric port.
import adc_dma_pkg::*;

module adc_dma_wr #(
    parameter int SMP_W      = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [31:0]       cfg_base,
    input  logic [CNT_W-1:0]  cfg_nwords,
    input  logic              adc_vld,
    input  logic [SMP_W-1:0]  adc_dat,
    output logic              sts_busy,
    output logic              sts_done,
    output logic              sts_ovf,
    output logic [CNT_W-1:0]  sts_wcnt,
    output logic              bus_vld,
    output logic              bus_we,
    output logic [31:0]       bus_addr,
    output logic [31:0]       bus_wdat,
    input  logic              bus_rdy
);
    function automatic logic [HALF_W-1:0] zext(input logic [SMP_W-1:0] s);
        logic [HALF_W-1:0] r;
        r = '0;
        r[SMP_W-1:0] = s;
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] b,
                                                    input logic [CNT_W-1:0]  idx);
        return b + WORD_W'(idx) * ADDR_STEP;
    endfunction

    state_t              state;
    logic [WORD_W-1:0]   base;
    logic [CNT_W-1:0]    nwords;
    logic [CNT_W-1:0]    push_cnt;
    logic                half;
    logic [HALF_W-1:0]   low;
    logic                aborting;

    logic                active;
    logic                abort_now;
    logic                end_abort;
    logic                capture;
    logic [WORD_W-1:0]   word;
    logic                push_ok;
    logic                last_push;
    logic                pop;
    logic                last_ack;
    logic                issue_ok;
    logic                nxt_avail;
    logic [WORD_W-1:0]   nxt_data;

    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_two;
    logic [WORD_W-1:0]   fifo_head;
    logic [WORD_W-1:0]   fifo_head_next;

    assign active    = (state != IDLE);
    assign abort_now = active && (cfg_abort || aborting);
    // An abort completes once no request is left hanging on the bus.
    assign end_abort = abort_now && (!bus_vld || bus_rdy);
    assign capture   = (state == CAPT) && !abort_now && adc_vld;
    assign word      = {zext(adc_dat), low};
    assign pop       = bus_vld && bus_rdy;
    assign push_ok   = capture && half && (!fifo_full || pop);
    assign last_push = push_ok && (push_cnt + CNT_W'(1) == nwords);
    assign last_ack  = pop && (state == DRAIN) && (sts_wcnt + CNT_W'(1) == nwords);
    assign issue_ok  = active && !abort_now;

    // After a pop the next word is either already queued behind the head or
    // is the one being pushed into a FIFO that held a single entry.
    assign nxt_avail = issue_ok && (fifo_two || (!fifo_empty && push_ok));
    assign nxt_data  = fifo_two ? fifo_head_next : word;

    assign sts_busy  = active;
    assign bus_we    = bus_vld;

    sync_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (end_abort),
        .push      (capture && half),
        .din       (word),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .two_plus  (fifo_two),
        .head      (fifo_head),
        .head_next (fifo_head_next)
    );

    always_ff @(posedge clk) begin
        if ((state == IDLE) && cfg_start) begin
            base   <= cfg_base & ~32'h3;
            nwords <= cfg_nwords;
        end
        if (capture && !half) begin
            low <= zext(adc_dat);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            aborting <= 1'b0;
            half     <= 1'b0;
            push_cnt <= '0;
            sts_done <= 1'b0;
            sts_ovf  <= 1'b0;
            sts_wcnt <= '0;
            bus_vld  <= 1'b0;
            bus_addr <= '0;
            bus_wdat <= '0;
        end else begin
            if (pop) begin
                sts_wcnt <= sts_wcnt + CNT_W'(1);
            end

            if (end_abort || last_ack) begin
                bus_vld <= 1'b0;
            end else if (pop) begin
                bus_vld <= nxt_avail;
                if (nxt_avail) begin
                    bus_addr <= word_addr(base, sts_wcnt + CNT_W'(1));
                    bus_wdat <= nxt_data;
                end
            end else if (!bus_vld && issue_ok && !fifo_empty) begin
                bus_vld  <= 1'b1;
                bus_addr <= word_addr(base, sts_wcnt);
                bus_wdat <= fifo_head;
            end

            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        push_cnt <= '0;
                        half     <= 1'b0;
                        sts_done <= (cfg_nwords == '0);
                        sts_ovf  <= 1'b0;
                        sts_wcnt <= '0;
                        state    <= (cfg_nwords == '0) ? IDLE : CAPT;
                    end
                end
                CAPT: begin
                    if (end_abort) begin
                        state    <= IDLE;
                        aborting <= 1'b0;
                        half     <= 1'b0;
                    end else if (abort_now) begin
                        aborting <= 1'b1;
                    end else if (capture) begin
                        half <= !half;
                        if (half) begin
                            if (push_ok) begin
                                push_cnt <= push_cnt + CNT_W'(1);
                                if (last_push) begin
                                    state <= DRAIN;
                                end
                            end else begin
                                sts_ovf <= 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (end_abort) begin
                        state    <= IDLE;
                        aborting <= 1'b0;
                        half     <= 1'b0;
                    end else if (abort_now) begin
                        aborting <= 1'b1;
                    end else if (last_ack) begin
                        state    <= IDLE;
                        sts_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/adc_dma_wr.md
Name: adc_dma_wr

Overview:
- DMA write master that converts the free-running ADC sample stream into 32-bit SDRAM writes.
- Sits directly upstream of the SOC fabric and drives the fabric's ADC master port (vld/we/addr/wdat/rdy).
- Packs two samples per word and buffers words in a small FIFO so SDRAM arbitration stalls do not lose data.
- Reports busy, done, overflow and written-word count to the CSR block.

Parameters:
- SMP_W, 12, ADC sample width; must be at most 16.
- FIFO_DEPTH, 8, packed-word FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 16, width of the word counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cfg_start  in  1  one-cycle pulse that starts a transfer
- cfg_abort  in  1  one-cycle pulse that aborts the current transfer
- cfg_base  in  32  SDRAM byte start address; bits [1:0] are ignored
- cfg_nwords  in  CNT_W  number of 32-bit words to write
- adc_vld  in  1  sample strobe; there is no backpressure on this input
- adc_dat  in  SMP_W  sample value
- sts_busy  out  1  high while in CAPT or DRAIN
- sts_done  out  1  sticky, set on normal completion
- sts_ovf  out  1  sticky, set when a packed word is dropped
- sts_wcnt  out  CNT_W  words acknowledged by SDRAM
- bus_vld  out  1  request to fabric
- bus_we  out  1  always 1 whenever bus_vld=1
- bus_addr  out  32  word-aligned byte address
- bus_wdat  out  32  write data
- bus_rdy  in  1  transaction complete

Behaviour:
- Reset: all outputs are 0, state is IDLE, FIFO is empty, packer half-flag is cleared. Reset asserted mid-transaction drops bus_vld on the next cycle.
- States are IDLE, CAPT and DRAIN.
- IDLE:
  - cfg_start latches base as {cfg_base[31:2],2'b00} and latches nwords.
  - cfg_start clears sts_done, sts_ovf and sts_wcnt.
  - If nwords=0, the block stays in IDLE and sts_done=1 on the next cycle.
  - Otherwise the block enters CAPT on the next cycle.
  - cfg_abort is ignored in IDLE. cfg_start and cfg_abort in the same cycle: start is taken.
- CAPT:
  - Each adc_vld cycle zero-extends adc_dat to 16 bits.
  - The first sample goes to the low half [15:0]; the second sample forms the word {s1,s0}, which is pushed.
  - The push counter increments only when a push succeeds.
  - A push succeeds if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the word is dropped, sts_ovf is set, and the packer restarts at the low half.
  - When the push counter reaches nwords, the block enters DRAIN. Further samples are ignored.
- DRAIN: when a bus_rdy brings sts_wcnt to nwords, sts_done=1 and the next state is IDLE.
- cfg_start while busy is ignored.
- Bus master, active in CAPT and DRAIN with outputs registered:
  - When the FIFO is not empty and no request is outstanding, the next cycle drives bus_vld=1, bus_we=1, bus_addr=base+4*sts_wcnt and bus_wdat=FIFO head.
  - Latency: a word pushed in cycle N gives bus_vld=1 in cycle N+1 at the earliest.
  - bus_addr and bus_wdat are held stable until the cycle with bus_rdy=1. SDRAM latches addr on vld and wdat a cycle later.
  - On bus_rdy: pop the FIFO and increment sts_wcnt.
  - If the FIFO still holds data after the pop, bus_vld stays 1 and addr/wdat advance on the next cycle (back-to-back). Otherwise bus_vld drops to 0.
  - bus_rdy while bus_vld=0 is ignored.
- Address arithmetic is 32-bit modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000).
- cfg_abort in CAPT or DRAIN:
  - Capture stops immediately.
  - An outstanding request keeps bus_vld and its addr/wdat until bus_rdy, and sts_wcnt counts it.
  - After that, the FIFO and packer are flushed and the block returns to IDLE.
  - sts_done stays 0. If no request is outstanding, IDLE is reached on the next cycle.

Decomposition:
- Package adc_dma_pkg holds:
  - the state enum {IDLE, CAPT, DRAIN};
  - HALF_W=16 and WORD_W=32;
  - the byte-address step constant (4).
- One sub-module, sync_fifo: parameterised width and depth, synchronous with push, pop, full, empty, head, and flush on clk/rst.

Test Plan:
- base=0x4000_0100, nwords=4, samples 0x001..0x008, bus_rdy 2 cycles after each vld -> writes (0x4000_0100,0x0002_0001), (0x4000_0104,0x0004_0003), (0x4000_0108,0x0006_0005), (0x4000_010C,0x0008_0007); done=1, wcnt=4, ovf=0, busy=0.
- nwords=16, samples every cycle, bus_rdy held 0 for 40 cycles then always 1 -> first 8 words contain consecutive sample pairs, ovf=1, 16 words are eventually written, done=1.
- nwords=0 with cfg_start -> done=1 on the next cycle, bus_vld never asserts, busy stays 0.
- base=0xFFFF_FFF8, nwords=3 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 in order.
- cfg_abort while bus_vld=1 with bus_rdy delayed 3 cycles -> vld/addr/wdat stable until rdy, then vld=0, busy=0, done=0, wcnt incremented by 1, FIFO empty.
- rst pulse during back-to-back writes -> all outputs 0 next cycle; a following start with nwords=1 and samples 0xAAA,0x555 writes 0x0555_0AAA.
